// File: rtl/seq_detector_param_if.sv
//------------------------------------------------------------------------------
// Module      : seq_detector_param_if
// Description : Sample/control inputs and registered status outputs of the
//               serial pattern detector.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) ();
    logic                         En;
    logic                         Clr;
    logic                         In1;
    logic                         Out1;
    logic [CNT_W-1:0]             Match_cnt;
    logic [$clog2(PAT_W+1)-1:0]   Prog;

    modport master (
        output En, Clr, In1,
        input  Out1, Match_cnt, Prog
    );

    modport slave (
        input  En, Clr, In1,
        output Out1, Match_cnt, Prog
    );
endinterface

`default_nettype wire

// File: rtl/seq_detector_param.sv
//------------------------------------------------------------------------------
// Module      : seq_detector_param
// Description : KMP-automaton serial pattern detector (MSB first) with
//               overlap option, sample enable and saturating match counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    seq_detector_param_if.slave   bus
);

    localparam int c_PROG_W = $clog2(PAT_W + 1);
    localparam int c_NSTATE = 2 ** c_PROG_W;

    // Bit i of the pattern in arrival order (i = 0 is received first).
    function automatic logic f_pbit(input int i);
        logic [PAT_W-1:0] v;
        v = PATTERN >> (PAT_W - 1 - i);
        return v[0];
    endfunction

    // Longest suffix of (prefix[0..s-1], b) that is a prefix of PATTERN.
    function automatic int f_next(input int s, input logic b);
        int   res;
        bit   found;
        bit   ok;
        int   idx;
        logic tbit;
        res   = 0;
        found = 1'b0;
        for (int k = s + 1; k >= 1; k--) begin
            if (!found) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    idx  = s + 1 - k + j;
                    tbit = (idx == s) ? b : f_pbit(idx);
                    if (tbit != f_pbit(j)) ok = 1'b0;
                end
                if (ok) begin
                    found = 1'b1;
                    res   = k;
                end
            end
        end
        return res;
    endfunction

    // Longest proper border of the whole pattern.
    function automatic int f_fail();
        int res;
        bit found;
        bit ok;
        res   = 0;
        found = 1'b0;
        for (int k = PAT_W - 1; k >= 1; k--) begin
            if (!found) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (f_pbit(PAT_W - k + j) != f_pbit(j)) ok = 1'b0;
                end
                if (ok) begin
                    found = 1'b1;
                    res   = k;
                end
            end
        end
        return res;
    endfunction

    localparam int                  c_FAIL_INT = f_fail();
    localparam logic [c_PROG_W-1:0] c_S_IDLE   = '0;
    localparam logic [c_PROG_W-1:0] c_S_FULL   = c_PROG_W'(PAT_W);
    localparam logic [c_PROG_W-1:0] c_S_FAIL   = c_PROG_W'(c_FAIL_INT);
    localparam logic [c_PROG_W-1:0] c_S_RESTART = OVERLAP ? c_S_FAIL : c_S_IDLE;
    localparam logic [CNT_W-1:0]    c_CNT_MAX  = '1;

    generate
        if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
            $error("seq_detector_param: PAT_W must be in 2..16");
        end
    endgenerate

    // Transition table, one entry per encodable state; unreachable codes pad to idle.
    logic [c_NSTATE-1:0][c_PROG_W-1:0] w_nxt0;
    logic [c_NSTATE-1:0][c_PROG_W-1:0] w_nxt1;

    generate
        for (genvar s = 0; s < c_NSTATE; s++) begin : g_tbl
            if (s < PAT_W) begin : g_live
                localparam int c_N0 = f_next(s, 1'b0);
                localparam int c_N1 = f_next(s, 1'b1);
                assign w_nxt0[s] = c_N0[c_PROG_W-1:0];
                assign w_nxt1[s] = c_N1[c_PROG_W-1:0];
            end else begin : g_pad
                assign w_nxt0[s] = c_S_IDLE;
                assign w_nxt1[s] = c_S_IDLE;
            end
        end
    endgenerate

    logic [c_PROG_W-1:0] r_state;
    logic                r_out1;
    logic [CNT_W-1:0]    r_cnt;

    logic [c_PROG_W-1:0] w_cand;
    logic [c_PROG_W-1:0] w_state_nx;
    logic                w_out1_nx;
    logic [CNT_W-1:0]    w_cnt_nx;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= c_S_IDLE;
            r_out1  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_out1  <= w_out1_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_cand     = bus.In1 ? w_nxt1[r_state] : w_nxt0[r_state];
        w_state_nx = r_state;
        w_out1_nx  = 1'b0;
        w_cnt_nx   = r_cnt;
        if (bus.Clr) begin
            w_state_nx = c_S_IDLE;
            w_cnt_nx   = '0;
        end else if (bus.En) begin
            if (w_cand == c_S_FULL) begin
                w_state_nx = c_S_RESTART;
                w_out1_nx  = 1'b1;
                if (r_cnt != c_CNT_MAX) w_cnt_nx = r_cnt + 1'b1;
            end else begin
                w_state_nx = w_cand;
            end
        end
    end

    assign bus.Out1      = r_out1;
    assign bus.Match_cnt = r_cnt;
    assign bus.Prog      = r_state;

endmodule

`default_nettype wire
